// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, sync-read imem port, prefetch FIFO and a
// valid/ready decode interface with redirect flush. Optional macro: FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int                ADDR_W      = 32,
  parameter int                INSTR_W     = 32,
  parameter int                INSTR_BYTES = 4,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [ADDR_W-1:0]  out_pc,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`else
  output logic [ADDR_W-1:0]  out_pc
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  tag_pc;
  logic               inflight;
  logic [INSTR_W-1:0] fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     credit_used;
  logic               pop;
  logic               push;
  logic               issue;

  // Credits count both queued entries and the fetch still in flight, so the
  // response of every issued request always has a free slot waiting for it.
  always_comb begin
    out_valid   = (count != '0) & ~redirect_valid;
    pop         = out_valid & out_ready;
    push        = inflight & ~redirect_valid;
    credit_used = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    issue       = rst_n & ~redirect_valid & (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    imem_req    = issue;
    imem_addr   = pc;
    out_instr   = fifo_instr[rd_ptr];
    out_pc      = fifo_pc[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (issue) begin
        pc     <= pc + ADDR_W'(INSTR_BYTES);
        tag_pc <= pc;
      end
      inflight <= issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pc[wr_ptr]    <= tag_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'(count) + 32'(inflight);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based model of issued-but-undelivered
// instructions predicts requests and delivery; a monitor checks every handshake.
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RST_PC   = 32'h100;
  localparam logic [31:0] DATA_KEY = 32'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_unit #(
    .ADDR_W(32), .INSTR_W(32), .INSTR_BYTES(4), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
`ifdef FETCH_PERF_CNT_EN
    .out_pc(out_pc), .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`else
    .out_pc(out_pc)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data for a requested address appears next cycle,
  // junk otherwise so the DUT must ignore it when nothing is in flight.
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ DATA_KEY) : $urandom();

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } entry_t;

  entry_t      exp_q[$];
  logic [31:0] model_pc = RST_PC;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  longint      flush_model = 0;
  bit          seen_reset = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rn, input bit rdy, input bit rv,
                               input logic [31:0] rpc, input int n);
    rst_n          = rn;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Predictor: an entry becomes deliverable two cycles after its issue; issue is
  // allowed while undelivered entries (minus this cycle's pop) leave room.
  always @(negedge clk) begin
    bit exp_valid, exp_pop, exp_req;
    cyc++;
    if (!rst_n) begin
      if (seen_reset) checkOutput("req_in_reset", 64'(imem_req), 64'd0);
      exp_q.delete();
      model_pc    = RST_PC;
      flush_model = 0;
      seen_reset  = 1;
    end else if (seen_reset) begin
      exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc) && !redirect_valid;
      exp_pop   = exp_valid && out_ready;
      exp_req   = !redirect_valid && ((exp_q.size() - int'(exp_pop)) < DEPTH);
      checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
      checkOutput("imem_req", 64'(imem_req), 64'(exp_req));
      if (exp_req) checkOutput("imem_addr", 64'(imem_addr), 64'(model_pc));
`ifdef FETCH_PERF_CNT_EN
      checkOutput("perf_fetch_cnt", 64'(perf_fetch_cnt), 64'(32'(hs_cnt)));
      checkOutput("perf_flush_cnt", 64'(perf_flush_cnt), 64'(32'(flush_model)));
`endif
      if (redirect_valid) begin
        flush_model += exp_q.size();
        exp_q.delete();
        model_pc = redirect_pc;
      end else if (exp_req) begin
        exp_q.push_back('{pc: model_pc, cyc: cyc});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // Monitor: every accepted instruction must be the oldest undelivered one.
  always @(negedge clk) begin
    entry_t e;
    #1;
    if (!rst_n) begin
      hs_cnt = 0;
    end else if (seen_reset && out_valid && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_pop", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        checkOutput("out_pc", 64'(out_pc), 64'(e.pc));
        checkOutput("out_instr", 64'(out_instr), 64'(e.pc ^ DATA_KEY));
      end
    end
  end

  initial begin
    applyStimulus(0, 1, 0, 32'h0, 3);
    $display("[TB] streaming from reset");
    applyStimulus(1, 1, 0, 32'h0, 20);
    $display("[TB] back-pressure");
    applyStimulus(1, 0, 0, 32'h0, 10);
    applyStimulus(1, 1, 0, 32'h0, 10);
    $display("[TB] redirect with full queue and fetch in flight");
    applyStimulus(1, 0, 0, 32'h0, 8);
    applyStimulus(1, 1, 0, 32'h0, 1);
    applyStimulus(1, 1, 1, 32'h2000, 1);
    applyStimulus(1, 1, 0, 32'h0, 10);
    $display("[TB] address wrap");
    applyStimulus(1, 1, 1, 32'hFFFF_FFF8, 1);
    applyStimulus(1, 1, 0, 32'h0, 8);
    $display("[TB] back-to-back redirects");
    applyStimulus(1, 1, 1, 32'h3000, 1);
    applyStimulus(1, 1, 1, 32'h4000, 1);
    applyStimulus(1, 1, 0, 32'h0, 8);
    $display("[TB] mid-stream reset");
    applyStimulus(0, 1, 0, 32'h0, 1);
    applyStimulus(1, 1, 0, 32'h0, 8);
    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus($urandom_range(0, 499) != 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0,
                    $urandom() & 32'hFFFF_FFFC, 1);
    end
    applyStimulus(1, 1, 0, 32'h0, 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
